// File: rtl/conv_window_streamer.sv
`default_nettype none
// ============================================================================
// Module   : conv_window_streamer
// Purpose  : Snapshots the A_DIM x A_DIM input matrix and the K_DIM x K_DIM
//            filter, then streams (activation, weight) pairs for every
//            valid-convolution window (row-major positions, row-major taps)
//            over a valid/ready handshake.
// Revision : 1.0  initial release
// ============================================================================
module conv_window_streamer #(
  parameter int  DATA_W = 8,
  parameter int  A_DIM  = 4,
  parameter int  K_DIM  = 3,
  localparam int O_DIM  = A_DIM - K_DIM + 1,
  localparam int POS_W  = $clog2(O_DIM * O_DIM),
  localparam int TAP_W  = $clog2(K_DIM * K_DIM)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [A_DIM*A_DIM*DATA_W-1:0]   a_flat,
  input  logic [K_DIM*K_DIM*DATA_W-1:0]   b_flat,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [DATA_W-1:0]               out_act,
  output logic [DATA_W-1:0]               out_wgt,
  output logic [POS_W-1:0]                out_pos,
  output logic [TAP_W-1:0]                out_tap,
  output logic                            out_last_tap,
  output logic                            out_last,
  output logic                            busy,
  output logic                            done
);

  localparam int C_NA    = A_DIM * A_DIM;
  localparam int C_NB    = K_DIM * K_DIM;
  localparam int C_KW    = (K_DIM > 1) ? $clog2(K_DIM) : 1;
  localparam int C_OW    = (O_DIM > 1) ? $clog2(O_DIM) : 1;
  localparam int C_IDX_W = $clog2(C_NA);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_STREAM = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [DATA_W-1:0] r_a [C_NA];
  logic [DATA_W-1:0] r_b [C_NB];

  logic [C_KW-1:0] r_kcol, r_krow;
  logic [C_OW-1:0] r_ocol, r_orow;

  logic w_stream, w_xfer;
  logic w_kcol_wrap, w_krow_wrap, w_ocol_wrap, w_orow_wrap;
  logic w_tap_last, w_pos_last;
  logic [TAP_W-1:0]   w_tap;
  logic [POS_W-1:0]   w_pos;
  logic [C_IDX_W-1:0] w_a_idx;

  assign w_stream    = (r_state == S_STREAM);
  assign w_xfer      = w_stream & out_ready;
  assign w_kcol_wrap = (r_kcol == C_KW'(K_DIM - 1));
  assign w_krow_wrap = (r_krow == C_KW'(K_DIM - 1));
  assign w_ocol_wrap = (r_ocol == C_OW'(O_DIM - 1));
  assign w_orow_wrap = (r_orow == C_OW'(O_DIM - 1));
  assign w_tap_last  = w_kcol_wrap & w_krow_wrap;
  assign w_pos_last  = w_ocol_wrap & w_orow_wrap;

  // Flattened indices: tap and position numbers, and the A element under the current tap
  assign w_tap   = TAP_W'(r_krow) * TAP_W'(K_DIM) + TAP_W'(r_kcol);
  assign w_pos   = POS_W'(r_orow) * POS_W'(O_DIM) + POS_W'(r_ocol);
  assign w_a_idx = (C_IDX_W'(r_orow) + C_IDX_W'(r_krow)) * C_IDX_W'(A_DIM)
                 + C_IDX_W'(r_ocol) + C_IDX_W'(r_kcol);

  // Data fields are forced to zero outside STREAM so idle outputs stay quiet
  assign out_act      = w_stream ? r_a[w_a_idx] : '0;
  assign out_wgt      = w_stream ? r_b[w_tap]   : '0;
  assign out_pos      = w_stream ? w_pos        : '0;
  assign out_tap      = w_stream ? w_tap        : '0;
  assign out_last_tap = w_stream & w_tap_last;
  assign out_last     = w_stream & w_tap_last & w_pos_last;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state and status outputs; start is only honoured in IDLE
  always_comb begin
    w_next    = r_state;
    out_valid = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (r_state)
      S_IDLE:   if (start) w_next = S_LOAD;
      S_LOAD: begin
        busy   = 1'b1;
        w_next = S_STREAM;
      end
      S_STREAM: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (w_xfer && w_tap_last && w_pos_last) w_next = S_DONE;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default:  w_next = S_IDLE;
    endcase
  end

  // Shadow copies of A and B, captured once per stream so input changes cannot disturb it
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < C_NA; i++) r_a[i] <= '0;
      for (int j = 0; j < C_NB; j++) r_b[j] <= '0;
    end else if (r_state == S_LOAD) begin
      for (int i = 0; i < C_NA; i++) r_a[i] <= a_flat[i*DATA_W +: DATA_W];
      for (int j = 0; j < C_NB; j++) r_b[j] <= b_flat[j*DATA_W +: DATA_W];
    end
  end

  // Nested window counters: kcol fastest, then krow, ocol, orow; advance only on a transfer
  always_ff @(posedge clk) begin
    if (rst || r_state == S_LOAD) begin
      r_kcol <= '0;
      r_krow <= '0;
      r_ocol <= '0;
      r_orow <= '0;
    end else if (w_xfer) begin
      if (!w_kcol_wrap) begin
        r_kcol <= r_kcol + 1'b1;
      end else begin
        r_kcol <= '0;
        if (!w_krow_wrap) begin
          r_krow <= r_krow + 1'b1;
        end else begin
          r_krow <= '0;
          if (!w_ocol_wrap) begin
            r_ocol <= r_ocol + 1'b1;
          end else begin
            r_ocol <= '0;
            r_orow <= w_orow_wrap ? '0 : r_orow + 1'b1;
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_conv_window_streamer.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv_window_streamer
// Purpose  : Directed, table-driven bench for conv_window_streamer.
// Revision : 1.0  initial release
// ============================================================================
module tb_conv_window_streamer;

  localparam int DATA_W = 8;
  localparam int A_DIM  = 4;
  localparam int K_DIM  = 3;
  localparam int NPAIR  = 36;

  logic        clk = 1'b0;
  logic        rst, start, out_ready;
  logic [A_DIM*A_DIM*DATA_W-1:0] a_flat;
  logic [K_DIM*K_DIM*DATA_W-1:0] b_flat;
  logic        out_valid, out_last_tap, out_last, busy, done;
  logic [7:0]  out_act, out_wgt;
  logic [1:0]  out_pos;
  logic [3:0]  out_tap;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int start_cyc = 0;

  conv_window_streamer #(.DATA_W(DATA_W), .A_DIM(A_DIM), .K_DIM(K_DIM)) dut (
    .clk(clk), .rst(rst), .start(start), .a_flat(a_flat), .b_flat(b_flat),
    .out_valid(out_valid), .out_ready(out_ready), .out_act(out_act), .out_wgt(out_wgt),
    .out_pos(out_pos), .out_tap(out_tap), .out_last_tap(out_last_tap),
    .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) if (done) done_cnt++;

  // a_kind 0: A(r,c)=r*4+c+1, 1: all 2, 2: all 0xFF.  b_kind 0: all 1, 1: B(r,c)=r*3+c+1
  // rdy_mode 0: ready held 1, 1: ready held 1, 2: 3-cycle stall at pos0 tap4, 3: random
  typedef struct packed {
    logic [1:0]       a_kind;
    logic [1:0]       b_kind;
    logic [1:0]       rdy_mode;
    logic             poke;
    logic [3:0][15:0] exp_sum;
    logic [3:0][15:0] exp_dot;
    logic [15:0]      exp_wsum;
  } vec_t;

  vec_t vecs [5];

  function automatic vec_t mk(int ak, int bk, int rm, int pk,
                              int s0, int s1, int s2, int s3,
                              int d0, int d1, int d2, int d3, int ws);
    vec_t v;
    v.a_kind = 2'(ak); v.b_kind = 2'(bk); v.rdy_mode = 2'(rm); v.poke = 1'(pk);
    v.exp_sum[0] = 16'(s0); v.exp_sum[1] = 16'(s1); v.exp_sum[2] = 16'(s2); v.exp_sum[3] = 16'(s3);
    v.exp_dot[0] = 16'(d0); v.exp_dot[1] = 16'(d1); v.exp_dot[2] = 16'(d2); v.exp_dot[3] = 16'(d3);
    v.exp_wsum = 16'(ws);
    return v;
  endfunction

  function automatic int a_elem(int kind, int r, int c);
    if (kind == 0) return r * 4 + c + 1;
    if (kind == 1) return 2;
    return 255;
  endfunction

  function automatic int b_elem(int kind, int r, int c);
    if (kind == 0) return 1;
    return r * 3 + c + 1;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_a(input int kind);
    for (int r = 0; r < A_DIM; r++)
      for (int c = 0; c < A_DIM; c++)
        a_flat[(r*A_DIM+c)*DATA_W +: DATA_W] = 8'(a_elem(kind, r, c));
  endtask

  task automatic set_b(input int kind);
    for (int r = 0; r < K_DIM; r++)
      for (int c = 0; c < K_DIM; c++)
        b_flat[(r*K_DIM+c)*DATA_W +: DATA_W] = 8'(b_elem(kind, r, c));
  endtask

  task automatic start_pulse();
    @(negedge clk);
    start = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_busy"},  busy, 0);
    chk({tag, "_done"},  done, 0);
    chk({tag, "_data"},  {out_act, out_wgt, out_pos, out_tap}, 0);
  endtask

  // Runs one full stream from table entry vi and checks every pair against the model
  task automatic run_vec(input int vi);
    vec_t v;
    int sum, dot, wsum, held, dcyc;
    bit first_seen, poked, got, dseen;
    v = vecs[vi];
    set_a(int'(v.a_kind));
    set_b(int'(v.b_kind));
    out_ready = 1'b1;
    done_cnt = 0;
    sum = 0; dot = 0; wsum = 0; held = 0;
    first_seen = 0; poked = 0;
    start_pulse();
    for (int k = 0; k < NPAIR; k++) begin
      int pos, tap, ea, ew, wn;
      pos = k / 9; tap = k % 9;
      ea = a_elem(int'(v.a_kind), pos / 2 + tap / 3, pos % 2 + tap % 3);
      ew = b_elem(int'(v.b_kind), tap / 3, tap % 3);
      got = 0; wn = 0;
      while (!got && wn < 50) begin
        @(negedge clk);
        start = 1'b0;
        if (v.poke && k == 10 && !poked) begin
          set_a(2);
          start = 1'b1;
          poked = 1;
        end
        case (v.rdy_mode)
          2'd2:    out_ready = !(k == 4 && held < 3);
          2'd3:    out_ready = 1'($urandom_range(0, 1));
          default: out_ready = 1'b1;
        endcase
        #1;
        if (!first_seen && out_valid) begin
          first_seen = 1;
          if (v.rdy_mode == 2'd0) chk("first_valid_cycle", cyc, start_cyc + 2);
        end
        if (out_valid && out_ready) begin
          got = 1;
          chk($sformatf("pair%0d", k),
              {out_act, out_wgt, out_pos, out_tap, out_last_tap, out_last},
              {8'(ea), 8'(ew), 2'(pos), 4'(tap), 1'(tap == 8), 1'(k == NPAIR - 1)});
          sum  += int'(out_act);
          wsum += int'(out_wgt);
          dot  += int'(out_act) * int'(out_wgt);
        end else if (v.rdy_mode == 2'd2 && k == 4 && out_valid) begin
          chk("stall_act", out_act, 6);
          chk("stall_tap", out_tap, 4);
          held++;
        end
        wn++;
      end
      if (!got) begin
        checks++; errors++;
        $display("FAIL pair_timeout vec=%0d pair=%0d actual=no_transfer required=transfer", vi, k);
        start = 1'b0;
        return;
      end
      if (tap == 8) begin
        chk($sformatf("win%0d_act_sum", pos), sum, int'(v.exp_sum[pos]));
        chk($sformatf("win%0d_dot", pos),     dot, int'(v.exp_dot[pos]));
        chk($sformatf("win%0d_wgt_sum", pos), wsum, int'(v.exp_wsum));
        sum = 0; dot = 0; wsum = 0;
      end
    end
    dseen = 0; dcyc = 0;
    for (int i = 0; i < 5 && !dseen; i++) begin
      @(negedge clk);
      start = 1'b0;
      out_ready = 1'b1;
      #1;
      if (done) begin dseen = 1; dcyc = cyc; end
    end
    chk("done_seen", dseen, 1);
    if (v.rdy_mode == 2'd0 && dseen) chk("done_cycle", dcyc, start_cyc + 38);
    repeat (4) @(negedge clk);
    #1;
    chk("done_count", done_cnt, 1);
    chk("busy_after", busy, 0);
    chk("valid_after", out_valid, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    vecs[0] = mk(0, 0, 0, 0,  54, 63, 90, 99,   54, 63, 90, 99,    9);
    vecs[1] = mk(1, 1, 1, 0,  18, 18, 18, 18,   90, 90, 90, 90,    45);
    vecs[2] = mk(0, 1, 2, 0,  54, 63, 90, 99,   348, 393, 528, 573, 45);
    vecs[3] = mk(0, 1, 3, 0,  54, 63, 90, 99,   348, 393, 528, 573, 45);
    vecs[4] = mk(0, 0, 0, 1,  54, 63, 90, 99,   54, 63, 90, 99,    9);

    rst = 1'b1; start = 1'b0; out_ready = 1'b0; a_flat = '0; b_flat = '0;
    repeat (2) @(negedge clk);
    #1;
    check_quiet("reset");
    rst = 1'b0;

    // Table-driven streams
    for (int i = 0; i < 4; i++) begin
      run_vec(i);
      if (i == 0) begin
        // Reset while idle with non-zero shadow contents
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check_quiet("idle_reset");
        rst = 1'b0;
      end
    end

    // Snapshot and start-ignore during STREAM
    run_vec(4);

    // Reset after 20 transfers, then a fresh complete stream
    set_a(0); set_b(0);
    out_ready = 1'b1;
    start_pulse();
    n = 0;
    for (int i = 0; i < 100 && n < 20; i++) begin
      @(negedge clk);
      #1;
      if (out_valid && out_ready) n++;
    end
    chk("midrst_transfers", n, 20);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check_quiet("midrst");
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("midrst_stays_idle", {out_valid, busy}, 0);
    run_vec(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
